// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma
// Description : Block copy / constant fill initiator for a 16-bit single-port
//               RAM with synchronous write and combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] remaining,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_zero = '0;
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] src_ptr_q,   src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q,   dst_ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] buf_q,       buf_d;
  logic [DATA_W-1:0] fill_q,      fill_d;
  logic              mode_q,      mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      fill_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    mode_d      = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != c_addr_zero) begin
            src_ptr_d   = src;
            dst_ptr_d   = dst;
            remaining_d = len;
            mode_d      = mode;
            fill_d      = fill_val;
            state_d     = mode ? S_WR : S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        buf_d     = mem_rdata;
        src_ptr_d = src_ptr_q + c_addr_one;
        state_d   = S_WR;
      end
      S_WR: begin
        dst_ptr_d   = dst_ptr_q + c_addr_one;
        remaining_d = remaining_q - c_addr_one;
        if (remaining_q == c_addr_one) begin
          state_d = S_DONE;
        end else begin
          state_d = mode_q ? S_WR : S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM-side outputs depend only on registered state so they are stable for the whole cycle.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_RD: begin
        busy     = 1'b1;
        mem_addr = src_ptr_q;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_ptr_q;
        mem_wdata = mode_q ? fill_q : buf_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign remaining = remaining_q;

endmodule
`default_nettype wire
